stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit stream multiplexer. Successor to the combinational 4:1 mux.
- Channel selection is decided by round-robin arbitration rather than an external select.
- Each channel has a valid/ready handshake; the output is a single registered stage.
- Sits between several producers and one shared consumer: debug/trace funnels, shared bus ports.

---
 rtl/stream_mux_rr.sv | 171 +++++++++++++++++
 tb/tb_stream_mux_rr.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   N_CH-channel, W-bit valid/ready stream multiplexer with round-robin
//   arbitration and a single registered output stage (full throughput).
//
// Build option:
//   STREAM_MUX_PKT_LOCK_EN  defined   : packet lock. Arbitration happens only
//                                       at packet boundaries (in_last), and
//                                       rr_ptr advances when a packet ends.
//                           undefined : every beat re-arbitrates, and rr_ptr
//                                       advances after every accepted beat.
//                                       in_last is passed through only.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel valid (bit i = channel i)
//   in_ready   per-channel ready (combinational)
//   in_data    packed channel data, channel i at [i*W +: W]
//   in_last    per-channel end-of-packet marker
//   out_valid  registered output valid
//   out_ready  consumer ready
//   out_data   registered output data
//   out_last   registered output last
//   out_sel    channel index of the beat held in the output register
// -----------------------------------------------------------------------------
module stream_mux_rr #(
  parameter  int N_CH  = 4,
  parameter  int W     = 4,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     in_valid,
  output logic [N_CH-1:0]     in_ready,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH-1:0]     in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  output logic [SEL_W-1:0]    out_sel
);

  logic [W-1:0]     ch_data_s [N_CH];

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic [SEL_W:0]   scan_sum_s;
  logic [SEL_W-1:0] scan_idx_s;
  logic [SEL_W-1:0] arb_grant_s;
  logic [SEL_W-1:0] grant_s;
  logic [SEL_W-1:0] grant_inc_s;
  logic             load_en_s;
  logic             grant_hit_s;
  logic             accept_s;

`ifdef STREAM_MUX_PKT_LOCK_EN
  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e           state_q;
  logic [SEL_W-1:0] lock_ch_q;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign ch_data_s[c] = in_data[c*W +: W];
  end

  // Round-robin scan: offsets are walked from highest to lowest so the
  // requester closest to rr_ptr (wrapping N_CH-1 -> 0) is the last one written.
  always_comb begin
    arb_grant_s = rr_ptr_q;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      scan_sum_s  = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
      scan_idx_s  = (scan_sum_s >= (SEL_W+1)'(N_CH)) ?
                    SEL_W'(scan_sum_s - (SEL_W+1)'(N_CH)) : SEL_W'(scan_sum_s);
      arb_grant_s = in_valid[scan_idx_s] ? scan_idx_s : arb_grant_s;
    end
  end

  // Grant selection and per-channel ready. Nothing is accepted while reset is
  // asserted, so in_ready stays low even though the output register is empty.
  always_comb begin
`ifdef STREAM_MUX_PKT_LOCK_EN
    grant_s = (state_q == ST_LOCK) ? lock_ch_q : arb_grant_s;
`else
    grant_s = arb_grant_s;
`endif
    load_en_s   = !out_valid_q || out_ready;
    // In ARB the scan defaults to rr_ptr, which is idle when nobody requests;
    // in LOCK a gap on lock_ch stalls instead of re-arbitrating.
    grant_hit_s = in_valid[grant_s];
    accept_s    = rst_n && load_en_s && grant_hit_s;
    grant_inc_s = (grant_s == SEL_W'(N_CH - 1)) ? '0 : grant_s + SEL_W'(1);
    in_ready    = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = accept_s && (grant_s == SEL_W'(i));
    end
  end

  // Next-state of the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = load_en_s ? accept_s : out_valid_q;
    out_data_d  = accept_s ? ch_data_s[grant_s] : out_data_q;
    out_last_d  = accept_s ? in_last[grant_s]   : out_last_q;
    out_sel_d   = accept_s ? grant_s            : out_sel_q;
`ifdef STREAM_MUX_PKT_LOCK_EN
    rr_ptr_d    = (accept_s && in_last[grant_s]) ? grant_inc_s : rr_ptr_q;
`else
    rr_ptr_d    = accept_s ? grant_inc_s : rr_ptr_q;
`endif
  end

  // State registers, including the packet-lock FSM when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      state_q     <= ST_ARB;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      case (state_q)
        ST_ARB: begin
          if (accept_s && !in_last[grant_s]) begin
            state_q   <= ST_LOCK;
            lock_ch_q <= grant_s;
          end else begin
            state_q   <= ST_ARB;
          end
        end
        ST_LOCK: begin
          if (accept_s && in_last[grant_s]) begin
            state_q <= ST_ARB;
          end else begin
            state_q <= ST_LOCK;
          end
        end
        default: begin
          state_q <= ST_ARB;
        end
      endcase
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//   Directed scenarios plus randomized traffic for stream_mux_rr (N_CH=4, W=4),
//   checked against a transaction-level reference model. Builds with or
//   without STREAM_MUX_PKT_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_sel;

  int checks   = 0;
  int failures = 0;

  // Pending beat per channel (held until the model says it was accepted).
  logic         cv [N];
  logic [W-1:0] cd [N];
  logic         cl [N];

  // Reference model state.
  int           m_rr;
  int           m_lock;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  int           m_sel;
  int           last_g;

  logic [W-1:0] rr_exp [5];

  stream_mux_rr #(.N_CH(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr    = 0;
    m_lock  = -1;
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    m_sel   = 0;
    last_g  = -1;
  endtask

  task automatic clear_chans();
    for (int i = 0; i < N; i++) begin
      cv[i] = 1'b0;
      cd[i] = '0;
      cl[i] = 1'b0;
    end
  endtask

  task automatic load(input int ch, input logic [W-1:0] d, input logic l);
    cv[ch] = 1'b1;
    cd[ch] = d;
    cl[ch] = l;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i]       = cv[i];
      in_data[i*W +: W] = cd[i];
      in_last[i]        = cl[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_chans();
    drive();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive pending beats, predict the grant from the
  // arbitration rules, check in_ready, then check the output register.
  task automatic step(input logic ordy);
    int           g;
    int           c;
    logic         load_ok;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    drive();
    out_ready = ordy;
    load_ok   = !m_valid || ordy;
    g         = -1;
    if (load_ok) begin
      if (m_lock >= 0) begin
        if (cv[m_lock]) g = m_lock;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (g < 0 && cv[c]) g = c;
        end
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = cd[g];
      m_last  = cl[g];
      m_sel   = g;
      cv[g]   = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (cl[g]) begin
        m_rr   = (g + 1) % N;
        m_lock = -1;
      end else begin
        m_lock = g;
      end
`else
      m_rr = (g + 1) % N;
`endif
    end else if (load_ok) begin
      m_valid = 1'b0;
    end
    last_g = g;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_last",  32'(out_last),  32'(m_last));
    chk("out_sel",   32'(out_sel),   32'(m_sel));
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    clear_chans();
    drive();
    model_reset();

    // Power-on reset values.
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_sel",   32'(out_sel),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;

    // Reset mid-stream: ch2 beat (not last) held under backpressure, ch1 waiting.
    load(2, 4'h6, 1'b0);
    step(1'b1);
    chk("mid_sel_before", 32'(out_sel), 32'd2);
    load(1, 4'h3, 1'b1);
    step(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_sel",   32'(out_sel),   32'd0);
    chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    load(0, 4'h1, 1'b1);
    step(1'b1);
    chk("post_rst_first_sel", 32'(out_sel), 32'd0);
    step(1'b1);
    chk("post_rst_second_sel", 32'(out_sel), 32'd1);
    step(1'b1);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Round-robin over four always-valid single-beat channels.
    do_reset();
    rr_exp = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
    for (int i = 0; i < N; i++) load(i, W'(10 + i), 1'b1);
    for (int s = 0; s < 5; s++) begin
      step(1'b1);
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_data",  32'(out_data),  32'(rr_exp[s]));
      chk("rr_sel",   32'(out_sel),   32'(s % N));
      if (last_g >= 0) load(last_g, W'(10 + last_g), 1'b1);
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock: ch1 three-beat packet while ch2 keeps requesting.
    do_reset();
    load(1, 4'h1, 1'b0);
    load(2, 4'h7, 1'b1);
    step(1'b1);
    chk("lock_b0", 32'(out_data), 32'h1);
    load(1, 4'h2, 1'b0);
    step(1'b1);
    chk("lock_b1", 32'(out_data), 32'h2);
    load(1, 4'h3, 1'b1);
    step(1'b1);
    chk("lock_b2", 32'(out_data), 32'h3);
    step(1'b1);
    chk("lock_ch2", 32'(out_data), 32'h7);
`endif

    // Backpressure: ch0 beat 5 held for three cycles.
    do_reset();
    load(0, 4'h5, 1'b1);
    step(1'b1);
    load(1, 4'h9, 1'b1);
    for (int s = 0; s < 3; s++) begin
      step(1'b0);
      chk("bp_hold_data",  32'(out_data),  32'h5);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    step(1'b1);
    chk("bp_next_data", 32'(out_data), 32'h9);

    // Wrap-around: rr_ptr=3 after ch2, then ch3 before ch0.
    do_reset();
    load(2, 4'hc, 1'b1);
    step(1'b1);
    load(0, 4'h4, 1'b1);
    load(3, 4'he, 1'b1);
    step(1'b1);
    chk("wrap_first",  32'(out_sel), 32'd3);
    step(1'b1);
    chk("wrap_second", 32'(out_sel), 32'd0);

    // Unknown data on ch3 must not leak into other channels' beats.
    do_reset();
    load(0, 4'd7,    1'b1);
    load(1, 4'd10,   1'b1);
    load(2, 4'd3,    1'b1);
    load(3, 4'bxxxx, 1'b1);
    step(1'b1);
    chk("x_ch0", 32'(out_data), 32'd7);
    step(1'b1);
    chk("x_ch1", 32'(out_data), 32'd10);
    step(1'b1);
    chk("x_ch2", 32'(out_data), 32'd3);
    step(1'b1);
    chk("x_ch3_sel", 32'(out_sel), 32'd3);

    // Randomized traffic with random backpressure and request gaps.
    do_reset();
    for (int s = 0; s < 600; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!cv[i] && $urandom_range(0, 2) != 0) begin
          load(i, W'($urandom), ($urandom_range(0, 2) == 0));
        end
      end
      step($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
